daten_ram_arbiter: RTL
======================

// Module: daten_ram_arbiter
// PURPOSE
//  Shares the single-port DatenRAM between two requesters: port 0 = CPU load/store unit,
//  port 1 = auxiliary master (loader/debug/LED-DMA). Round-robin arbitration with optional
//  locked bursts; bounded burst length guarantees neither port starves. Sits in Top between
//  the CPU data interface, the auxiliary master and DatenRAM (1-cycle registered read).
// PARAMETERS
//  ADDR_W     8   word address width (DatenRAM = 256 words)
//  DATA_W     32  data word width
//  MAX_BURST  4   max consecutive grants to one locked owner before forced rotation (>=1)
// PORTS
//  clk_25mhz   in   1       system clock, all state on rising edge
//  reset       in   1       synchronous, active-high reset
//  req0/req1   in   1       request valid, port 0 / port 1
//  we0/we1     in   1       1 = write, 0 = read
//  lock0/lock1 in   1       request to keep ownership for next beat (burst)
//  addr0/addr1 in   ADDR_W  word address
//  wdata0/1    in   DATA_W  write data
//  gnt0/gnt1   out  1       request accepted this cycle (combinational)
//  rvalid0/1   out  1       read data valid (one cycle after granted read)
//  rdata0/1    out  DATA_W  read data, meaningful only while rvalidN=1
//  ram_en      out  1       RAM access this cycle
//  ram_we      out  1       RAM write enable
//  ram_addr    out  ADDR_W  RAM address
//  ram_wdata   out  DATA_W  RAM write data
//  ram_rdata   in   DATA_W  RAM read data, valid cycle after ram_en & !ram_we
// BEHAVIOUR
//  - Reset: state=IDLE, last=1 (port 0 wins first tie), burst_cnt=0, rvalid0/1=0, gnt0/1=0,
//    ram_en=ram_we=0. A read granted in the reset cycle produces no rvalid.
//  - States: IDLE, OWN0, OWN1 (registered); burst_cnt width $clog2(MAX_BURST)+1.
//  - At most one gnt per cycle; gntN=1 only if reqN=1. Request held until gnt (no retraction).
//  - IDLE: only one req -> grant it; both -> grant port != last; none -> no grant.
//  - On grant to N: last<=N; if lockN=1 and MAX_BURST>1 -> OWNN, burst_cnt<=1; else IDLE.
//  - OWNN: if reqN=1 -> grant N, burst_cnt++; stay OWNN while lockN=1 and burst_cnt+1<MAX_BURST,
//    else ->IDLE with burst_cnt<=0. If reqN=0 -> ownership dropped same cycle, arbitrate as IDLE
//    (other port may be granted without bubble), last stays N.
//  - After forced rotation (burst_cnt reached MAX_BURST) the other port, if requesting, wins
//    next cycle via last=N tie rule.
//  - RAM mux: ram_en=gnt0|gnt1; ram_we/addr/wdata from granted port; zero when no grant.
//  - Read latency 1: granted read in cycle t -> rvalidN=1 and rdataN=ram_rdata in t+1,
//    exactly one pulse; writes never raise rvalid. rdata of non-owner port held at 0.
//  - Back-to-back: a port may be granted every cycle; read/write interleave with no bubble.
//  - Same-address write then read (any ports): read in later cycle returns written data
//    (RAM ordering; arbiter adds no reordering).
//  - lockN ignored in cycles where reqN=0 or gntN=0.
// TESTING
//  1 Reset: assert reset 2 cycles with req0=req1=1 -> gnt0/1, rvalid0/1, ram_en all 0;
//    first cycle after reset both req read -> gnt0=1, gnt1=0.
//  2 Single port: port 0 writes 0xDEADBEEF @0x10, then reads @0x10 -> gnt each cycle,
//    rvalid0=1 one cycle after read with rdata0=0xDEADBEEF, rvalid1 never set.
//  3 Round-robin: both ports continuous unlocked reads @0x01/@0x02 -> grants alternate
//    0,1,0,1...; each rvalid follows its own grant by exactly 1 cycle with correct data.
//  4 Burst limit: port 1 lock1=1 reading 6 words @0x20.., port 0 requesting -> port 1 gets
//    4 consecutive grants (MAX_BURST=4), then port 0 granted, then port 1 resumes.
//  5 Owner drops: OWN0, req0 falls while req1=1 -> gnt1 same cycle, no idle bubble.
//  6 Reset mid-burst: reset in cycle after granted read -> no rvalid, state IDLE, last=1.

Source files
------------

// File: rtl/daten_ram_arbiter.sv
// daten_ram_arbiter
//   Shares the single-port DatenRAM between the CPU load/store unit (port 0) and an
//   auxiliary master (port 1). Round-robin arbitration with optional locked bursts;
//   a locked owner is forced to rotate after MAX_BURST consecutive grants.
//
// Ports
//   clk_25mhz, reset        clock, synchronous active-high reset
//   reqN/weN/lockN          request, write enable, burst lock for port N
//   addrN/wdataN            word address and write data for port N
//   gntN                    request accepted this cycle (combinational)
//   rvalidN/rdataN          read data one cycle after a granted read (rdataN=0 otherwise)
//   ram_en/ram_we           RAM access strobe and write enable
//   ram_addr/ram_wdata      RAM address and write data (zero when idle)
//   ram_rdata               RAM read data, valid the cycle after a read access
module daten_ram_arbiter #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic              clk_25mhz,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic              lock0,
    input  logic              lock1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam int unsigned CNT_W = $clog2(MAX_BURST) + 1;

    typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} state_t;

    state_t           state_q, state_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
    logic             rvalid0_q, rvalid1_q;

    logic             owner_cont;
    logic             lock_g;
    logic [CNT_W-1:0] cnt_next;

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        burst_cnt_d = burst_cnt_q;
        gnt0        = 1'b0;
        gnt1        = 1'b0;
        owner_cont  = 1'b0;
        lock_g      = 1'b0;
        cnt_next    = '0;

        if (!reset) begin
            if (state_q == StOwn0 && req0) begin
                gnt0       = 1'b1;
                owner_cont = 1'b1;
            end else if (state_q == StOwn1 && req1) begin
                gnt1       = 1'b1;
                owner_cont = 1'b1;
            end else if (req0 && (!req1 || last_q)) begin
                // Owner absent (or idle): plain round-robin, last_q=1 favours port 0.
                gnt0 = 1'b1;
            end else if (req1) begin
                gnt1 = 1'b1;
            end

            if (gnt0 || gnt1) begin
                lock_g   = gnt0 ? lock0 : lock1;
                // A fresh grant starts a burst at count 1; covers MAX_BURST==1 too.
                cnt_next = owner_cont ? burst_cnt_q + CNT_W'(1) : CNT_W'(1);
                last_d   = gnt1;
                if (lock_g && cnt_next < CNT_W'(MAX_BURST)) begin
                    state_d     = gnt0 ? StOwn0 : StOwn1;
                    burst_cnt_d = cnt_next;
                end else begin
                    state_d     = StIdle;
                    burst_cnt_d = '0;
                end
            end else begin
                state_d     = StIdle;
                burst_cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk_25mhz) begin
        if (reset) begin
            state_q     <= StIdle;
            last_q      <= 1'b1;
            burst_cnt_q <= '0;
            rvalid0_q   <= 1'b0;
            rvalid1_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            burst_cnt_q <= burst_cnt_d;
            rvalid0_q   <= gnt0 & ~we0;
            rvalid1_q   <= gnt1 & ~we1;
        end
    end

    // A read answered into a reset cycle is discarded.
    assign rvalid0 = rvalid0_q & ~reset;
    assign rvalid1 = rvalid1_q & ~reset;
    assign rdata0  = rvalid0 ? ram_rdata : '0;
    assign rdata1  = rvalid1 ? ram_rdata : '0;

    always_comb begin
        ram_en    = gnt0 | gnt1;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (gnt0) begin
            ram_we    = we0;
            ram_addr  = addr0;
            ram_wdata = wdata0;
        end else if (gnt1) begin
            ram_we    = we1;
            ram_addr  = addr1;
            ram_wdata = wdata1;
        end
    end

endmodule
